// File: rtl/led_pkg.sv
// Shared definitions for the LED mode sequencer: mode encodings, entry
// patterns and the counter width helper.
package led_pkg;

    localparam int unsigned MODE_W = 2;
    localparam int unsigned RUN_W  = 3;

    typedef enum logic [MODE_W-1:0] {
        MODE_OFF   = 2'd0,
        MODE_FLASH = 2'd1,
        MODE_RUN   = 2'd2,
        MODE_ALL   = 2'd3
    } mode_e;

    localparam logic [RUN_W-1:0] RUN_INIT = 3'b001;
    localparam logic [RUN_W-1:0] RUN_FULL = 3'b111;

    // Pattern register payload driven onto the LED bank
    typedef struct packed {
        logic             flash;
        logic [RUN_W-1:0] run;
    } led_pat_t;

    // Bits needed to count 0..n-1, never less than one
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic mode_e next_mode(input mode_e m);
        mode_e nm;
        case (m)
            MODE_OFF:   nm = MODE_FLASH;
            MODE_FLASH: nm = MODE_RUN;
            MODE_RUN:   nm = MODE_ALL;
            default:    nm = MODE_OFF;
        endcase
        return nm;
    endfunction

    function automatic led_pat_t entry_pattern(input mode_e m);
        led_pat_t p;
        p = '0;
        case (m)
            MODE_FLASH: p.flash = 1'b1;
            MODE_RUN:   p.run   = RUN_INIT;
            MODE_ALL: begin
                p.flash = 1'b1;
                p.run   = RUN_FULL;
            end
            default: ;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Shared prescaler: emits a one-cycle TICK every TICK_DIV unheld cycles,
// restartable from zero by clr.
module led_tick_gen
    import led_pkg::*;
#(
    parameter int unsigned TICK_DIV = 12_500_000
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    input  logic hold,
    output logic TICK
);

    localparam int unsigned       CNT_W   = cnt_width(TICK_DIV);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count;

    // clr wins over hold so a mode change always starts a full period
    always_ff @(posedge CLK) begin
        if (RST) begin
            count <= '0;
            TICK  <= 1'b0;
        end else if (clr) begin
            count <= '0;
            TICK  <= 1'b0;
        end else if (hold) begin
            TICK  <= 1'b0;
        end else if (count == CNT_MAX) begin
            count <= '0;
            TICK  <= 1'b1;
        end else begin
            count <= count + CNT_W'(1);
            TICK  <= 1'b0;
        end
    end

endmodule

// File: rtl/led_pattern_ctrl.sv
// LED bank mode sequencer: OFF -> FLASH -> RUN -> ALL, advanced by key
// or by dwell expiry, stepping patterns on the shared tick.
module led_pattern_ctrl
    import led_pkg::*;
#(
    parameter int unsigned TICK_DIV    = 12_500_000,
    parameter int unsigned DWELL_TICKS = 16,
    parameter bit          AUTO_EN     = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             KEY_NEXT,
    input  logic             HOLD,
    output logic             FLASH_LED,
    output logic [RUN_W-1:0] RUN_LED,
    output logic [MODE_W-1:0] MODE,
    output logic             TICK
);

    localparam int unsigned        DWELL_W   = cnt_width(DWELL_TICKS);
    localparam logic [DWELL_W-1:0] DWELL_MAX = DWELL_W'(DWELL_TICKS - 1);

    mode_e              mode_q, mode_d;
    led_pat_t           pat_q, pat_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               step_c;
    logic               expiry_c;
    logic               advance_c;

    led_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .CLK  (CLK),
        .RST  (RST),
        .clr  (advance_c),
        .hold (HOLD),
        .TICK (TICK)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            mode_q  <= MODE_OFF;
            pat_q   <= '0;
            dwell_q <= '0;
        end else begin
            mode_q  <= mode_d;
            pat_q   <= pat_d;
            dwell_q <= dwell_d;
        end
    end

    // An advancing tick loads the entry pattern instead of stepping
    always_comb begin
        mode_d    = mode_q;
        pat_d     = pat_q;
        dwell_d   = dwell_q;
        step_c    = TICK && !HOLD;
        expiry_c  = AUTO_EN && step_c && (dwell_q == DWELL_MAX);
        advance_c = KEY_NEXT || expiry_c;

        if (advance_c) begin
            mode_d  = next_mode(mode_q);
            pat_d   = entry_pattern(next_mode(mode_q));
            dwell_d = '0;
        end else if (step_c) begin
            if (dwell_q != DWELL_MAX) begin
                dwell_d = dwell_q + DWELL_W'(1);
            end
            case (mode_q)
                MODE_FLASH: pat_d.flash = ~pat_q.flash;
                MODE_RUN:   pat_d.run   = {pat_q.run[RUN_W-2:0], pat_q.run[RUN_W-1]};
                default: ;
            endcase
        end
    end

    assign MODE      = mode_q;
    assign FLASH_LED = pat_q.flash;
    assign RUN_LED   = pat_q.run;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Scoreboard bench for led_pattern_ctrl: one auto-advance instance and one
// key-only instance, expectations queued as {mode, flash, run, tick}.
module tb_led_pattern_ctrl;

    localparam int unsigned TD = 4;
    localparam int unsigned DT = 3;

    logic       clk = 1'b0;
    logic       rst_a, key_a, hold_a, flash_a, tick_a;
    logic [2:0] run_a;
    logic [1:0] mode_a;
    logic       rst_m, key_m, hold_m, flash_m, tick_m;
    logic [2:0] run_m;
    logic [1:0] mode_m;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [6:0] sb[$];
    logic [6:0] obs;
    logic [6:0] exp_v;

    always #5 clk = ~clk;

    led_pattern_ctrl #(.TICK_DIV(TD), .DWELL_TICKS(DT), .AUTO_EN(1'b1)) dut_a (
        .CLK(clk), .RST(rst_a), .KEY_NEXT(key_a), .HOLD(hold_a),
        .FLASH_LED(flash_a), .RUN_LED(run_a), .MODE(mode_a), .TICK(tick_a)
    );

    led_pattern_ctrl #(.TICK_DIV(TD), .DWELL_TICKS(DT), .AUTO_EN(1'b0)) dut_m (
        .CLK(clk), .RST(rst_m), .KEY_NEXT(key_m), .HOLD(hold_m),
        .FLASH_LED(flash_m), .RUN_LED(run_m), .MODE(mode_m), .TICK(tick_m)
    );

    function automatic logic [6:0] ev(input logic [1:0] m, input logic f,
                                      input logic [2:0] r, input logic t);
        return {m, f, r, t};
    endfunction

    // Pattern steps already applied t cycles after a mode entry
    function automatic int steps_at(input int t);
        return (t <= 0) ? 0 : (t - 1) / TD;
    endfunction

    function automatic logic is_tick(input int t);
        return (t > 0) && (t % TD == 0);
    endfunction

    function automatic logic [2:0] run_after(input int steps);
        logic [2:0] r;
        r = 3'b001;
        for (int i = 0; i < steps % 3; i++) r = {r[1:0], r[2]};
        return r;
    endfunction

    task automatic test_reset();
        rst_a = 1'b1; key_a = 1'b0; hold_a = 1'b0;
        repeat (2) @(posedge clk);
        sb.push_back(ev(2'd0, 1'b0, 3'b000, 1'b0));
        @(negedge clk);
        obs = {mode_a, flash_a, run_a, tick_a};
        exp_v = sb.pop_front();
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL reset_state: got %b expected %b", obs, exp_v);
        end
        rst_a = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            if (k <= 12) sb.push_back(ev(2'd0, 1'b0, 3'b000, is_tick(k)));
            else         sb.push_back(ev(2'd1, 1'b1, 3'b000, 1'b0));
        end
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            obs = {mode_a, flash_a, run_a, tick_a};
            exp_v = sb.pop_front();
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL reset_tick_seq cycle %0d: got %b expected %b", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_flash();
        for (int j = 1; j <= 13; j++) begin
            if (j < 13) sb.push_back(ev(2'd1, steps_at(j) % 2 == 0, 3'b000, is_tick(j)));
            else        sb.push_back(ev(2'd2, 1'b0, 3'b001, 1'b0));
        end
        for (int j = 1; j <= 13; j++) begin
            @(negedge clk);
            obs = {mode_a, flash_a, run_a, tick_a};
            exp_v = sb.pop_front();
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL flash_step cycle %0d: got %b expected %b", j, obs, exp_v);
            end
        end
    endtask

    task automatic test_collision();
        for (int j = 1; j <= 12; j++)
            sb.push_back(ev(2'd2, 1'b0, run_after(steps_at(j)), is_tick(j)));
        for (int j = 1; j <= 12; j++)
            sb.push_back(ev(2'd3, 1'b1, 3'b111, j == 1 ? 1'b0 : is_tick(j - 1)));
        sb.push_back(ev(2'd3, 1'b1, 3'b111, 1'b1));
        sb.push_back(ev(2'd0, 1'b0, 3'b000, 1'b0));
        for (int c = 1; c <= 26; c++) begin
            @(negedge clk);
            obs = {mode_a, flash_a, run_a, tick_a};
            exp_v = sb.pop_front();
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL key_expiry_collision cycle %0d: got %b expected %b", c, obs, exp_v);
            end
            key_a = (c == 12);
        end
    endtask

    task automatic test_hold();
        for (int c = 1; c <= 13; c++) sb.push_back(ev(2'd1, 1'b1, 3'b000, 1'b0));
        for (int c = 14; c <= 26; c++) sb.push_back(ev(2'd2, 1'b0, 3'b001, c == 27 - 0 ? 1'b0 : (c == 27 ? 1'b1 : 1'b0)));
        sb.push_back(ev(2'd2, 1'b0, 3'b001, 1'b1));
        sb.push_back(ev(2'd2, 1'b0, 3'b010, 1'b0));
        key_a = 1'b1;
        for (int c = 1; c <= 28; c++) begin
            @(negedge clk);
            obs = {mode_a, flash_a, run_a, tick_a};
            exp_v = sb.pop_front();
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL hold_freeze cycle %0d: got %b expected %b", c, obs, exp_v);
            end
            key_a = (c == 13);
            if (c == 3)  hold_a = 1'b1;
            if (c == 23) hold_a = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        sb.push_back(ev(2'd0, 1'b0, 3'b000, 1'b0));
        for (int r = 1; r <= 5; r++) sb.push_back(ev(2'd0, 1'b0, 3'b000, r == 4));
        rst_a = 1'b1;
        key_a = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            obs = {mode_a, flash_a, run_a, tick_a};
            exp_v = sb.pop_front();
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL reset_mid_run cycle %0d: got %b expected %b", c, obs, exp_v);
            end
            rst_a = 1'b0;
            key_a = 1'b0;
        end
    endtask

    task automatic test_run_rotation();
        key_m = 1'b0; hold_m = 1'b0;
        @(negedge clk);
        rst_m = 1'b0;
        key_m = 1'b1;
        sb.push_back(ev(2'd1, 1'b1, 3'b000, 1'b0));
        sb.push_back(ev(2'd2, 1'b0, 3'b001, 1'b0));
        for (int t = 1; t <= 40; t++)
            sb.push_back(ev(2'd2, 1'b0, run_after(steps_at(t)), is_tick(t)));
        for (int c = 1; c <= 42; c++) begin
            @(negedge clk);
            obs = {mode_m, flash_m, run_m, tick_m};
            exp_v = sb.pop_front();
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL run_rotation cycle %0d: got %b expected %b", c, obs, exp_v);
            end
            if (c == 2) key_m = 1'b0;
        end
    endtask

    initial begin
        rst_a = 1'b1; key_a = 1'b0; hold_a = 1'b0;
        rst_m = 1'b1; key_m = 1'b0; hold_m = 1'b0;
        test_reset();
        test_flash();
        test_collision();
        test_hold();
        test_reset_mid();
        test_run_rotation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
